// File: rtl/inst_ctrl_pkg.sv
// Shared types and constants for the instruction/config front-end controller.
package inst_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DLD   = 3'd4
    } state_t;

    localparam int unsigned DEF_TBITS     = 64;
    localparam logic [63:0] DEF_INST_HEAD = 64'hefef123abbeeff22;
    localparam logic [63:0] DEF_DATA_HEAD = 64'hefef6543dadaff11;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_STRAY      = 3'd1;
    localparam logic [2:0] ERR_EARLY_LAST = 3'd2;
    localparam logic [2:0] ERR_NO_LAST    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd4;

endpackage

// File: rtl/inst_cfg_regs.sv
// CFG_WORDS x TBITS configuration register file, flattened onto cfg_bus
// (word i at bits [i*TBITS +: TBITS]); synchronous clear.
module inst_cfg_regs
    import inst_ctrl_pkg::*;
#(
    parameter int unsigned TBITS     = DEF_TBITS,
    parameter int unsigned CFG_WORDS = 3,
    parameter int unsigned IW        = 2
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [IW-1:0]              wr_idx,
    input  logic [TBITS-1:0]           wr_data,
    output logic [CFG_WORDS*TBITS-1:0] cfg_bus
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cfg_bus <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < CFG_WORDS; i++) begin
                if (wr_idx == IW'(i)) begin
                    cfg_bus[i*TBITS +: TBITS] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/inst_cfg_ctrl.sv
// Instruction/config front-end: pops FIFO words, captures config after INST_HEAD,
// starts the layer FSM or data loader. Optional RUN/DLD watchdog: CTRL_TIMEOUT_EN.
module inst_cfg_ctrl
    import inst_ctrl_pkg::*;
#(
    parameter int unsigned       TBITS       = DEF_TBITS,
    parameter int unsigned       CFG_WORDS   = 3,
    parameter logic [TBITS-1:0]  INST_HEAD   = TBITS'(DEF_INST_HEAD),
    parameter logic [TBITS-1:0]  DATA_HEAD   = TBITS'(DEF_DATA_HEAD),
    parameter int unsigned       TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [TBITS-1:0]           fifo_data_din,
    input  logic                       fifo_last_din,
    input  logic                       fifo_empty_n_din,
    output logic                       fifo_read_dout,
    input  logic                       layer_done,
    input  logic                       dataload_done,
    output logic [CFG_WORDS*TBITS-1:0] cfg_bus,
    output logic                       cfg_valid,
    output logic                       start,
    output logic                       dld_start,
    output logic                       busy,
    output logic                       err,
    output logic [2:0]                 err_code
);

    localparam int unsigned IW       = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(CFG_WORDS - 1);

    state_t        state, nxt_state;
    logic [IW-1:0] cnt, nxt_cnt;
    logic          wr_en;
    logic          set_err;
    logic [2:0]    nxt_code;
    logic          clr_valid;
    logic          timeout;

`ifdef CTRL_TIMEOUT_EN
    logic [15:0] wdog;

    always_ff @(posedge clk) begin
        if (reset || (nxt_state != state)) begin
            wdog <= '0;
        end else if (state == RUN || state == DLD) begin
            wdog <= wdog + 16'd1;
        end
    end

    assign timeout = (wdog == 16'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^(32'(TIMEOUT_CYC));
    assign timeout = 1'b0;
`endif

    // Gated by reset so a word at the FIFO head is not lost while the FSM is held.
    assign fifo_read_dout = fifo_empty_n_din & ~reset & ((state == IDLE) | (state == CFG));

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        wr_en     = 1'b0;
        set_err   = 1'b0;
        nxt_code  = err_code;
        clr_valid = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_read_dout) begin
                    if (fifo_data_din == INST_HEAD) begin
                        nxt_state = CFG;
                        nxt_cnt   = '0;
                        clr_valid = 1'b1;
                    end else if (fifo_data_din == DATA_HEAD) begin
                        nxt_state = DLD;
                    end else begin
                        set_err  = 1'b1;
                        nxt_code = ERR_STRAY;
                    end
                end
            end
            CFG: begin
                // A header before the first config word re-synchronises the frame.
                if (fifo_read_dout && !(fifo_data_din == INST_HEAD && cnt == '0)) begin
                    wr_en = 1'b1;
                    if (cnt == LAST_IDX) begin
                        if (fifo_last_din) begin
                            nxt_state = START;
                        end else begin
                            nxt_state = IDLE;
                            set_err   = 1'b1;
                            nxt_code  = ERR_NO_LAST;
                            clr_valid = 1'b1;
                        end
                    end else if (fifo_last_din) begin
                        nxt_state = IDLE;
                        set_err   = 1'b1;
                        nxt_code  = ERR_EARLY_LAST;
                        clr_valid = 1'b1;
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
            end
            START: nxt_state = RUN;
            RUN: begin
                if (layer_done) begin
                    nxt_state = IDLE;
                end else if (timeout) begin
                    nxt_state = IDLE;
                    set_err   = 1'b1;
                    nxt_code  = ERR_TIMEOUT;
                    clr_valid = 1'b1;
                end
            end
            DLD: begin
                if (dataload_done) begin
                    nxt_state = IDLE;
                end else if (timeout) begin
                    nxt_state = IDLE;
                    set_err   = 1'b1;
                    nxt_code  = ERR_TIMEOUT;
                    clr_valid = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            start     <= 1'b0;
            dld_start <= 1'b0;
            busy      <= 1'b0;
            cfg_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            start     <= (nxt_state == START);
            dld_start <= (nxt_state == DLD) && (state != DLD);
            busy      <= (nxt_state == START) || (nxt_state == RUN) || (nxt_state == DLD);
            if (clr_valid) begin
                cfg_valid <= 1'b0;
            end else if (nxt_state == START) begin
                cfg_valid <= 1'b1;
            end
            if (set_err) begin
                err      <= 1'b1;
                err_code <= nxt_code;
            end
        end
    end

    inst_cfg_regs #(
        .TBITS     (TBITS),
        .CFG_WORDS (CFG_WORDS),
        .IW        (IW)
    ) u_regs (
        .clk     (clk),
        .clr     (reset),
        .wr_en   (wr_en),
        .wr_idx  (cnt),
        .wr_data (fifo_data_din),
        .cfg_bus (cfg_bus)
    );

endmodule
